// File: rtl/serial_stream_gen_if.sv
// serial_stream_gen_if
//   Handshake and serial-output bundle for serial_stream_gen.
//   data_in    : parallel word, sampled only on an accept edge
//   data_valid : upstream has a word on data_in
//   data_ready : generator can take a word this cycle
//   w          : serial bit stream to the detector
//   w_valid    : w carries a data bit
//   busy       : generator is shifting a word
//   frame_done : last bit of a word is on w
//   master = upstream / observer side, slave = the generator itself.
interface serial_stream_gen_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             w;
    logic             w_valid;
    logic             busy;
    logic             frame_done;

    modport master (
        output data_in, data_valid,
        input  data_ready, w, w_valid, busy, frame_done
    );

    modport slave (
        input  data_in, data_valid,
        output data_ready, w, w_valid, busy, frame_done
    );
endinterface

// File: rtl/serial_stream_gen.sv
// serial_stream_gen
//   Takes parallel words over a valid/ready handshake and shifts them out
//   one bit per clk on w. A new word may be accepted in the cycle the last
//   bit of the current word is on w, so back-to-back frames form a gapless
//   bitstream for the downstream sequence detector.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_stream_gen_if.slave (data_in/data_valid/data_ready,
//           w/w_valid/busy/frame_done; all outputs except data_ready are
//           registered)
module serial_stream_gen #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_stream_gen_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PREV_IDX = CNT_W'(WIDTH - 2);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
    // Holds the bits not yet placed on w, aligned so the next one sits at
    // the shift-out end.
    logic [WIDTH-1:0]   sreg, sreg_nxt;
    logic               w_r, w_nxt;
    logic               w_valid_r, w_valid_nxt;
    logic               busy_r, busy_nxt;
    logic               frame_done_r, frame_done_nxt;

    logic last_bit;
    logic ready;
    logic accept;

    assign last_bit = (state == SHIFT) && (bit_cnt == LAST_IDX);
    assign ready    = (state == IDLE) || last_bit;
    assign accept   = bus.data_valid && ready;

    assign bus.data_ready = ready;
    assign bus.w          = w_r;
    assign bus.w_valid    = w_valid_r;
    assign bus.busy       = busy_r;
    assign bus.frame_done = frame_done_r;

    // State register (plus the datapath registers it steers)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            sreg         <= '0;
            w_r          <= IDLE_LEVEL;
            w_valid_r    <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state        <= state_nxt;
            bit_cnt      <= bit_cnt_nxt;
            sreg         <= sreg_nxt;
            w_r          <= w_nxt;
            w_valid_r    <= w_valid_nxt;
            busy_r       <= busy_nxt;
            frame_done_r <= frame_done_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last_bit && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        bit_cnt_nxt    = bit_cnt;
        sreg_nxt       = sreg;
        w_nxt          = IDLE_LEVEL;
        w_valid_nxt    = 1'b0;
        frame_done_nxt = 1'b0;
        busy_nxt       = (state_nxt == SHIFT);

        if (accept) begin
            // First bit goes straight to w; the rest wait in sreg.
            bit_cnt_nxt = '0;
            w_valid_nxt = 1'b1;
            if (MSB_FIRST) begin
                w_nxt    = bus.data_in[WIDTH-1];
                sreg_nxt = {bus.data_in[WIDTH-2:0], 1'b0};
            end else begin
                w_nxt    = bus.data_in[0];
                sreg_nxt = {1'b0, bus.data_in[WIDTH-1:1]};
            end
        end else if (state == SHIFT) begin
            if (last_bit) begin
                bit_cnt_nxt = '0;
                sreg_nxt    = '0;
            end else begin
                bit_cnt_nxt    = bit_cnt + CNT_W'(1);
                w_valid_nxt    = 1'b1;
                // Pulse on the edge that moves bit WIDTH-1 onto w.
                frame_done_nxt = (bit_cnt == PREV_IDX);
                if (MSB_FIRST) begin
                    w_nxt    = sreg[WIDTH-1];
                    sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
                end else begin
                    w_nxt    = sreg[0];
                    sreg_nxt = {1'b0, sreg[WIDTH-1:1]};
                end
            end
        end
    end
endmodule
